// File: rtl/mpu_rx_decoder.sv
// Responder side of an 8080-style MPU write bus: decodes the NT35510 command stream and emits pixel strobes.
// Optional macro MPU_RX_FRAME_CNT_EN enables the completed-frame counter on o_frame_cnt.
module mpu_rx_decoder #(
    parameter int HRES_WIDTH  = 9,
    parameter int VRES_WIDTH  = 10,
    parameter int DATA_WIDTH  = 24,
    parameter int H_MAX       = 479,
    parameter int V_MAX       = 799,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_sysclk,
    input  logic                  i_arstn,
    input  logic                  i_csx,
    input  logic                  i_dcx,
    input  logic                  i_wrx,
    input  logic                  i_rdx,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic                  o_pix_valid,
    output logic [HRES_WIDTH-1:0] o_pix_x,
    output logic [VRES_WIDTH-1:0] o_pix_y,
    output logic [DATA_WIDTH-1:0] o_pix_rgb,
    output logic                  o_cmd_valid,
    output logic [7:0]            o_cmd,
    output logic                  o_prm_valid,
    output logic [7:0]            o_prm,
    output logic                  o_disp_on,
    output logic                  o_sleep,
    output logic                  o_rd_err,
    output logic [15:0]           o_frame_cnt
);

    localparam int LAST = SYNC_STAGES - 1;

    typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_PARAM} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] csxSync_q, dcxSync_q, wrxSync_q, rdxSync_q;
    logic [DATA_WIDTH-1:0]  dSync_q [SYNC_STAGES];
    logic                   wrxPrev_q;

    logic [1:0]            byteCnt_q, byteCnt_d;
    logic [7:0]            startHi_q, startHi_d, startLo_q, startLo_d, endHi_q, endHi_d;
    logic [HRES_WIDTH-1:0] xs_q, xs_d, xe_q, xe_d, x_q, x_d;
    logic [VRES_WIDTH-1:0] ys_q, ys_d, ye_q, ye_d, y_q, y_d;
    logic                  pixValid_q, pixValid_d;
    logic [HRES_WIDTH-1:0] pixX_q, pixX_d;
    logic [VRES_WIDTH-1:0] pixY_q, pixY_d;
    logic [DATA_WIDTH-1:0] pixRgb_q, pixRgb_d;
    logic                  cmdValid_q, cmdValid_d, prmValid_q, prmValid_d;
    logic [7:0]            cmd_q, cmd_d, prm_q, prm_d;
    logic                  dispOn_q, dispOn_d, sleep_q, sleep_d, rdErr_q, rdErr_d;
`ifdef MPU_RX_FRAME_CNT_EN
    logic [15:0]           frameCnt_q, frameCnt_d;
`endif

    logic                  writeEvt, cmdEvt, dataEvt;
    logic [DATA_WIDTH-1:0] busD;
    logic [7:0]            cmdCode, prmByte;

    // Synchronisers reset to idle bus levels so releasing reset never fakes a WRX edge.
    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            csxSync_q <= '1;
            dcxSync_q <= '1;
            wrxSync_q <= '1;
            rdxSync_q <= '1;
            for (int i = 0; i < SYNC_STAGES; i++) dSync_q[i] <= '0;
            wrxPrev_q <= 1'b1;
        end else begin
            csxSync_q <= {csxSync_q[SYNC_STAGES-2:0], i_csx};
            dcxSync_q <= {dcxSync_q[SYNC_STAGES-2:0], i_dcx};
            wrxSync_q <= {wrxSync_q[SYNC_STAGES-2:0], i_wrx};
            rdxSync_q <= {rdxSync_q[SYNC_STAGES-2:0], i_rdx};
            dSync_q[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) dSync_q[i] <= dSync_q[i-1];
            wrxPrev_q <= wrxSync_q[LAST];
        end
    end

    assign writeEvt = wrxSync_q[LAST] & ~wrxPrev_q & ~csxSync_q[LAST];
    assign cmdEvt   = writeEvt & ~dcxSync_q[LAST];
    assign dataEvt  = writeEvt & dcxSync_q[LAST];
    assign busD     = dSync_q[LAST];
    assign cmdCode  = busD[15:8];
    assign prmByte  = busD[7:0];

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Commands pre-empt whatever sequence is in flight; address sets fall back to idle after the 4th byte.
    always_comb begin
        state_d = state_q;
        if (cmdEvt) begin
            case (cmdCode)
                8'h2A:                      state_d = S_CASET;
                8'h2B:                      state_d = S_RASET;
                8'h2C, 8'h3C:               state_d = S_RAMWR;
                8'h10, 8'h11, 8'h28, 8'h29: state_d = S_IDLE;
                default:                    state_d = S_PARAM;
            endcase
        end else if (dataEvt && (state_q == S_CASET || state_q == S_RASET) && byteCnt_q == 2'd3) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        byteCnt_d  = byteCnt_q;
        startHi_d  = startHi_q;
        startLo_d  = startLo_q;
        endHi_d    = endHi_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ys_d       = ys_q;
        ye_d       = ye_q;
        x_d        = x_q;
        y_d        = y_q;
        pixValid_d = 1'b0;
        pixX_d     = pixX_q;
        pixY_d     = pixY_q;
        pixRgb_d   = pixRgb_q;
        cmdValid_d = 1'b0;
        cmd_d      = cmd_q;
        prmValid_d = 1'b0;
        prm_d      = prm_q;
        dispOn_d   = dispOn_q;
        sleep_d    = sleep_q;
        rdErr_d    = rdErr_q | (~rdxSync_q[LAST] & ~csxSync_q[LAST]);
`ifdef MPU_RX_FRAME_CNT_EN
        frameCnt_d = frameCnt_q;
`endif

        if (cmdEvt) begin
            cmdValid_d = 1'b1;
            cmd_d      = cmdCode;
            byteCnt_d  = 2'd0;
            case (cmdCode)
                8'h2C: begin
                    x_d = xs_q;
                    y_d = ys_q;
                end
                8'h10:   sleep_d  = 1'b1;
                8'h11:   sleep_d  = 1'b0;
                8'h28:   dispOn_d = 1'b0;
                8'h29:   dispOn_d = 1'b1;
                default: ;
            endcase
        end else if (dataEvt && state_q == S_RAMWR) begin
            pixValid_d = 1'b1;
            pixX_d     = x_q;
            pixY_d     = y_q;
            pixRgb_d   = busD;
            // Row wrap goes back to XS; with XS > XE this fires on every pixel.
            if (x_q >= xe_q) begin
                x_d = xs_q;
                if (y_q >= ye_q) begin
                    y_d = ys_q;
`ifdef MPU_RX_FRAME_CNT_EN
                    frameCnt_d = frameCnt_q + 16'd1;
`endif
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end else if (dataEvt) begin
            prmValid_d = 1'b1;
            prm_d      = prmByte;
            if (state_q == S_CASET || state_q == S_RASET) begin
                byteCnt_d = byteCnt_q + 2'd1;
                case (byteCnt_q)
                    2'd0: startHi_d = prmByte;
                    2'd1: startLo_d = prmByte;
                    2'd2: endHi_d   = prmByte;
                    default: begin
                        if (state_q == S_CASET) begin
                            xs_d = HRES_WIDTH'({startHi_q, startLo_q});
                            xe_d = HRES_WIDTH'({endHi_q, prmByte});
                        end else begin
                            ys_d = VRES_WIDTH'({startHi_q, startLo_q});
                            ye_d = VRES_WIDTH'({endHi_q, prmByte});
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_arstn) begin
        if (!i_arstn) begin
            byteCnt_q  <= '0;
            startHi_q  <= '0;
            startLo_q  <= '0;
            endHi_q    <= '0;
            xs_q       <= '0;
            xe_q       <= HRES_WIDTH'(H_MAX);
            ys_q       <= '0;
            ye_q       <= VRES_WIDTH'(V_MAX);
            x_q        <= '0;
            y_q        <= '0;
            pixValid_q <= 1'b0;
            pixX_q     <= '0;
            pixY_q     <= '0;
            pixRgb_q   <= '0;
            cmdValid_q <= 1'b0;
            cmd_q      <= '0;
            prmValid_q <= 1'b0;
            prm_q      <= '0;
            dispOn_q   <= 1'b0;
            sleep_q    <= 1'b1;
            rdErr_q    <= 1'b0;
`ifdef MPU_RX_FRAME_CNT_EN
            frameCnt_q <= '0;
`endif
        end else begin
            byteCnt_q  <= byteCnt_d;
            startHi_q  <= startHi_d;
            startLo_q  <= startLo_d;
            endHi_q    <= endHi_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ys_q       <= ys_d;
            ye_q       <= ye_d;
            x_q        <= x_d;
            y_q        <= y_d;
            pixValid_q <= pixValid_d;
            pixX_q     <= pixX_d;
            pixY_q     <= pixY_d;
            pixRgb_q   <= pixRgb_d;
            cmdValid_q <= cmdValid_d;
            cmd_q      <= cmd_d;
            prmValid_q <= prmValid_d;
            prm_q      <= prm_d;
            dispOn_q   <= dispOn_d;
            sleep_q    <= sleep_d;
            rdErr_q    <= rdErr_d;
`ifdef MPU_RX_FRAME_CNT_EN
            frameCnt_q <= frameCnt_d;
`endif
        end
    end

    assign o_pix_valid = pixValid_q;
    assign o_pix_x     = pixX_q;
    assign o_pix_y     = pixY_q;
    assign o_pix_rgb   = pixRgb_q;
    assign o_cmd_valid = cmdValid_q;
    assign o_cmd       = cmd_q;
    assign o_prm_valid = prmValid_q;
    assign o_prm       = prm_q;
    assign o_disp_on   = dispOn_q;
    assign o_sleep     = sleep_q;
    assign o_rd_err    = rdErr_q;
`ifdef MPU_RX_FRAME_CNT_EN
    assign o_frame_cnt = frameCnt_q;
`else
    assign o_frame_cnt = 16'd0;
`endif

endmodule

// File: doc/mpu_rx_decoder.md
Name: mpu_rx_decoder

Overview:
- Responder end of the 8080-style MPU write bus driven toward the NT35510 panel.
- Samples CSX/DCX/WRX/D, decodes the command stream (column set, page set, RAM write, RAM write continue, display and sleep controls) and tracks the panel address pointer.
- Emits one pixel strobe with x/y/rgb per data write.
- Used as an on-chip panel model for bench/loopback checking of the MPU master, and as a capture front end feeding a framebuffer.

Parameters:
- HRES_WIDTH, 9, column address width.
- VRES_WIDTH, 10, page address width.
- DATA_WIDTH, 24, bus data width (must be >= 16).
- H_MAX, 479, reset value of column end address XE.
- V_MAX, 799, reset value of page end address YE.
- SYNC_STAGES, 2, synchroniser depth on all bus inputs (>= 2).

Ports:
- i_sysclk  in  1  system clock.
- i_arstn  in  1  asynchronous active-low reset.
- i_csx  in  1  chip select, low = selected.
- i_dcx  in  1  0 = command, 1 = data.
- i_wrx  in  1  write strobe; data latched on rising edge.
- i_rdx  in  1  read strobe (monitored only).
- i_d  in  DATA_WIDTH  bus data.
- o_pix_valid  out  1  one-cycle pixel strobe.
- o_pix_x  out  HRES_WIDTH  pixel column.
- o_pix_y  out  VRES_WIDTH  pixel page.
- o_pix_rgb  out  DATA_WIDTH  pixel data.
- o_cmd_valid  out  1  one-cycle strobe per command write.
- o_cmd  out  8  last command code.
- o_prm_valid  out  1  one-cycle strobe per parameter write outside RAM write.
- o_prm  out  8  parameter byte.
- o_disp_on  out  1  display-on status.
- o_sleep  out  1  sleep status.
- o_rd_err  out  1  sticky flag: RDX low while CSX low.
- o_frame_cnt  out  16  completed frame count (optional feature).

Behaviour:
- Synchronisation and capture:
  - i_csx, i_dcx, i_wrx, i_rdx and i_d all pass through identical SYNC_STAGES flop chains.
  - A write event is a 0->1 on synchronised WRX while synchronised CSX = 0.
  - DCX and D are taken from the same pipeline stage as the WRX edge.
  - Writes with CSX = 1 are ignored.
- Latency: outputs are registered one clock after the edge is detected, i.e. SYNC_STAGES+1 clocks after the first clock that samples i_wrx high.
- Command decode: when DCX = 0, code = D[15:8]; pulse o_cmd_valid and load o_cmd, then act on the code:
  - 0x2A: go to S_CASET, byte counter = 0.
  - 0x2B: go to S_RASET, byte counter = 0.
  - 0x2C: pointer x = XS, y = YS; go to S_RAMWR.
  - 0x3C: pointer unchanged; go to S_RAMWR.
  - 0x10: o_sleep = 1.
  - 0x11: o_sleep = 0.
  - 0x28: o_disp_on = 0.
  - 0x29: o_disp_on = 1.
  - Any other code: go to S_PARAM.
  - A command always pre-empts the current state, including mid-CASET/RASET; partial address bytes are discarded and XS/XE/YS/YE keep their old values.
- States: S_IDLE, S_CASET, S_RASET, S_RAMWR, S_PARAM.
  - S_CASET / S_RASET: 4 data writes, taken from D[7:0] in order start[15:8], start[7:0], end[15:8], end[7:0].
    - Values are committed on the 4th byte, truncated to HRES_WIDTH / VRES_WIDTH.
    - Then return to S_IDLE; further data writes go to S_PARAM handling.
    - o_prm_valid pulses for each of these bytes.
  - S_PARAM and S_IDLE data writes: pulse o_prm_valid with o_prm = D[7:0].
  - S_RAMWR: each data write pulses o_pix_valid with the current x, y and o_pix_rgb = D.
    - After the pixel, if x >= XE then x = XS and y advances; otherwise x = x+1.
    - y advances as: if y >= YE then y = YS (frame complete); otherwise y = y+1.
    - With XS > XE every pixel wraps the row.
- CSX rising does not leave S_RAMWR; a later data write after CSX is reasserted continues the stream with no new command.
- RDX low with CSX low sets o_rd_err (sticky until reset); no read data is driven.
- Reset (async, i_arstn = 0):
  - State S_IDLE, all strobes 0, o_cmd/o_prm/o_pix_* = 0.
  - XS = YS = 0, XE = H_MAX, YE = V_MAX, x = y = 0.
  - o_disp_on = 0, o_sleep = 1, o_rd_err = 0, o_frame_cnt = 0.
  - Synchroniser flops reset to idle bus levels: CSX = 1, WRX = 1, RDX = 1, DCX = 1, D = 0. No spurious edge is generated on release.
  - Reset mid-stream discards all partial state.

Optional Feature:
- Macro MPU_RX_FRAME_CNT_EN.
- Defined: o_frame_cnt increments (wrapping at 16 bits) on every frame complete, i.e. the y wrap from YE to YS in S_RAMWR.
- Undefined: counter logic is omitted and o_frame_cnt is tied to 0.

Test Plan:
- Reset release with bus idle, then command 0x11 and 0x29 -> o_cmd_valid pulses twice; o_sleep = 0, o_disp_on = 1; no o_pix_valid.
- CASET bytes 00,0A,00,0C; RASET 00,05,00,06; RAMWR; 6 pixels 0x000001..0x000006 -> (x,y) = (10,5),(11,5),(12,5),(10,6),(11,6),(12,6); frame count +1 if enabled.
- RAMWR, 3 pixels, CSX high 5 clocks, RAMWRC, 2 pixels -> 5 contiguous pixel coordinates, none repeated.
- CASET with 2 bytes, then RAMWR -> XS/XE unchanged (0/479); first pixel at (0,0).
- Single WRX rising edge with SYNC_STAGES = 2 -> o_pix_valid high exactly 1 clock, 3 clocks after first high sample; write with CSX = 1 -> no strobe.
- RDX pulse low with CSX low -> o_rd_err = 1, held until i_arstn asserted, then 0.
